// File: rtl/bm_xor_engine_pkg.sv
// Widths and index helpers shared by the bit-matrix XOR engine and its row reducer.
// Edit the geometry here; every other file derives from these values.
package bm_xor_engine_pkg;

  localparam int K_MAX         = 4;
  localparam int M_MAX         = 4;
  localparam int W             = 4;
  localparam int PACKET_LENGTH = 2;

  localparam int ROW_W = K_MAX * W;
  localparam int ROWS  = M_MAX * W;
  localparam int IN_W  = ROW_W * PACKET_LENGTH;
  localparam int OUT_W = ROWS * PACKET_LENGTH;

  localparam int K_IDX_W   = $clog2(K_MAX + 1);
  localparam int M_IDX_W   = $clog2(M_MAX + 1);
  localparam int ROW_IDX_W = $clog2(ROWS);

  function automatic int sub_idx(input int k, input int j);
    return (k * W + j) * PACKET_LENGTH;
  endfunction

  function automatic int row_idx(input int m, input int wi);
    return m * W + wi;
  endfunction

endpackage

// File: rtl/bm_xor_row.sv
// One bit-matrix row: XOR of every enabled, selected data sub-packet.
// Purely combinational, no latency, no flow control.
module bm_xor_row
  import bm_xor_engine_pkg::*;
(
  input  logic [ROW_W-1:0]         i_row,
  input  logic [ROW_W-1:0]         i_ch_en,
  input  logic [IN_W-1:0]          i_data,
  output logic [PACKET_LENGTH-1:0] o_par
);

  always_comb begin
    o_par = '0;
    for (int k = 0; k < K_MAX; k++) begin
      for (int j = 0; j < W; j++) begin
        if (i_row[k*W+j] && i_ch_en[k*W+j]) begin
          o_par = o_par ^ i_data[sub_idx(k, j) +: PACKET_LENGTH];
        end
      end
    end
  end

endmodule

// File: rtl/bm_xor_engine.sv
// GF(2) bit-matrix encoder with runtime K/M; two register stages, one beat per cycle.
// valid/ready backpressure holds up to two beats; config writes only land while idle.
module bm_xor_engine
  import bm_xor_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_wr,
  input  logic [ROW_IDX_W-1:0] cfg_row,
  input  logic [ROW_W-1:0]     cfg_data,
  input  logic                 cfg_dims_wr,
  input  logic [K_IDX_W-1:0]   cfg_k,
  input  logic [M_IDX_W-1:0]   cfg_m,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [M_MAX-1:0]     out_mask,
  output logic                 busy,
  output logic [15:0]          beat_cnt
);

  logic [ROW_W-1:0]   r_bm [ROWS];
  logic [K_IDX_W-1:0] r_k_act;
  logic [M_IDX_W-1:0] r_m_act;
  logic               r_s1_vld;
  logic [IN_W-1:0]    r_s1_dat;
  logic               r_out_vld;
  logic [OUT_W-1:0]   r_out_dat;
  logic [M_MAX-1:0]   r_out_mask;
  logic               r_cfg_err;
  logic [15:0]        r_beat_cnt;

  logic               w_busy;
  logic               w_cfg_req;
  logic               w_cfg_idle;
  logic               w_row_ok;
  logic               w_dims_ok;
  logic               w_bm_we;
  logic               w_dims_we;
  logic               w_cfg_rej;
  logic               w_s2_can_load;
  logic               w_in_rdy;
  logic               w_in_hs;
  logic               w_out_hs;
  logic [ROW_W-1:0]   w_ch_en;
  logic [M_MAX-1:0]   w_m_en;
  logic [OUT_W-1:0]   w_par;

  assign w_busy        = r_s1_vld || r_out_vld;
  assign w_cfg_req     = cfg_wr || cfg_dims_wr;
  assign w_cfg_idle    = !w_busy && !in_valid;
  assign w_row_ok      = {1'b0, cfg_row} < (ROW_IDX_W+1)'(ROWS);
  assign w_dims_ok     = (cfg_k != '0) && (cfg_k <= K_IDX_W'(K_MAX)) &&
                         (cfg_m != '0) && (cfg_m <= M_IDX_W'(M_MAX));
  assign w_bm_we       = cfg_wr && w_cfg_idle && w_row_ok;
  assign w_dims_we     = cfg_dims_wr && w_cfg_idle && w_dims_ok;
  assign w_cfg_rej     = (cfg_wr && !(w_cfg_idle && w_row_ok)) ||
                         (cfg_dims_wr && !(w_cfg_idle && w_dims_ok));

  // A pending config write steals the input port so it can never race a new beat.
  assign w_s2_can_load = !r_out_vld || out_ready;
  assign w_in_rdy      = !w_cfg_req && (!r_s1_vld || w_s2_can_load);
  assign w_in_hs       = in_valid && w_in_rdy;
  assign w_out_hs      = r_out_vld && out_ready;

  for (genvar gk = 0; gk < K_MAX; gk++) begin : g_ch_en
    assign w_ch_en[gk*W +: W] = {W{K_IDX_W'(gk) < r_k_act}};
  end

  for (genvar gm = 0; gm < M_MAX; gm++) begin : g_par_m
    assign w_m_en[gm] = M_IDX_W'(gm) < r_m_act;
    for (genvar gw = 0; gw < W; gw++) begin : g_par_w
      logic [PACKET_LENGTH-1:0] w_row_par;
      bm_xor_row u_row (
        .i_row   (r_bm[row_idx(gm, gw)]),
        .i_ch_en (w_ch_en),
        .i_data  (r_s1_dat),
        .o_par   (w_row_par)
      );
      assign w_par[row_idx(gm, gw)*PACKET_LENGTH +: PACKET_LENGTH] =
        w_m_en[gm] ? w_row_par : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) r_bm[r] <= '0;
      r_k_act   <= K_IDX_W'(K_MAX);
      r_m_act   <= M_IDX_W'(M_MAX);
      r_cfg_err <= 1'b0;
    end else begin
      if (w_bm_we) r_bm[cfg_row] <= cfg_data;
      if (w_dims_we) begin
        r_k_act <= cfg_k;
        r_m_act <= cfg_m;
      end
      r_cfg_err <= w_cfg_rej;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_dat   <= '0;
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_mask <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_s1_vld <= 1'b1;
        r_s1_dat <= in_data;
      end else if (w_s2_can_load) begin
        r_s1_vld <= 1'b0;
      end
      // Parity is captured from the current bm/dims; config can't change while a beat is in flight.
      if (w_s2_can_load) begin
        r_out_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_out_dat  <= w_par;
          r_out_mask <= w_m_en;
        end
      end
      if (w_out_hs) r_beat_cnt <= r_beat_cnt + 16'd1;
    end
  end

  assign cfg_err   = r_cfg_err;
  assign in_ready  = w_in_rdy;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_mask  = r_out_mask;
  assign busy      = w_busy;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_bm_xor_engine.sv
// Scoreboard bench for bm_xor_engine: a reference model predicts each beat at input handshake.
module tb_bm_xor_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_row = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_dims_wr = 1'b0;
  logic [2:0]  cfg_k = '0;
  logic [2:0]  cfg_m = '0;
  logic        cfg_err;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_mask;
  logic        busy;
  logic [15:0] beat_cnt;

  bm_xor_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr(cfg_wr), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .cfg_dims_wr(cfg_dims_wr), .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  logic [15:0] mbm [16];
  int          mk = 4;
  int          mm = 4;
  logic [15:0] mcnt = '0;
  logic        exp_err = 1'b0;
  logic [35:0] sb [$];
  logic        rnd_bp = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] d);
    logic [31:0] o;
    logic [3:0]  msk;
    o = '0;
    msk = '0;
    for (int m = 0; m < 4; m++) begin
      msk[m] = (m < mm);
      if (m < mm) begin
        for (int w = 0; w < 4; w++)
          for (int k = 0; k < mk; k++)
            for (int j = 0; j < 4; j++)
              if (mbm[m*4+w][k*4+j]) o[(m*4+w)*2 +: 2] = o[(m*4+w)*2 +: 2] ^ d[(k*4+j)*2 +: 2];
      end
    end
    return {msk, o};
  endfunction

  // Reference model and scoreboard, sampled mid-cycle for the coming edge.
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst_n) begin
      sb.delete();
      for (int r = 0; r < 16; r++) mbm[r] = '0;
      mk = 4;
      mm = 4;
      mcnt = '0;
      exp_err = 1'b0;
    end else begin
      check("cfg_err", cfg_err, exp_err);
      check("beat_cnt", beat_cnt, mcnt);
      check("busy", busy, sb.size() != 0);
      check("in_ready", in_ready, !(cfg_wr || cfg_dims_wr) && (sb.size() < 2 || out_ready));
      exp_err = 1'b0;
      if (cfg_wr) begin
        if (sb.size() == 0 && !in_valid && int'(cfg_row) < 16) mbm[cfg_row] = cfg_data;
        else exp_err = 1'b1;
      end
      if (cfg_dims_wr) begin
        if (sb.size() == 0 && !in_valid && cfg_k >= 1 && cfg_k <= 4 && cfg_m >= 1 && cfg_m <= 4) begin
          mk = int'(cfg_k);
          mm = int'(cfg_m);
        end else exp_err = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = sb.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_mask", out_mask, e[35:32]);
        end
        mcnt = mcnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data));
        n_acc++;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [3:0] r, input logic [15:0] d);
    cfg_wr = 1'b1; cfg_row = r; cfg_data = d;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_dims(input logic [2:0] k, input logic [2:0] m);
    cfg_dims_wr = 1'b1; cfg_k = k; cfg_m = m;
    @(posedge clk); #1;
    cfg_dims_wr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  logic [31:0] held;

  initial begin
    // Reset values
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mask", out_mask, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    // Identity on channel 0, k=4 m=1, with latency check
    cfg_dims(3'd4, 3'd1);
    for (int w = 0; w < 4; w++) cfg_write(4'(w), 16'(1 << w));
    send(32'h0000_001F);
    check("lat_edge1_valid", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_valid", out_valid, 1);
    check("ident_data", out_data, 32'h0000_001F);
    check("ident_mask", out_mask, 4'b0001);
    drain();

    // XOR of channels 0 and 1; channel 2 masked by k_act=2
    cfg_dims(3'd2, 3'd1);
    for (int w = 0; w < 4; w++) cfg_write(4'(w), 16'((1 << w) | (1 << (4 + w))));
    send(32'h00FF_DF1F);
    @(posedge clk); #1;
    check("xor_data", out_data, 32'h0000_00C0);
    check("xor_mask", out_mask, 4'b0001);
    drain();

    // Random matrices and data under random backpressure
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) cfg_dims(3'd3, 3'd2); else cfg_dims(3'd4, 3'd4);
      for (int r = 0; r < 16; r++) cfg_write(4'(r), 16'($urandom));
      rnd_bp = 1'b1;
      for (int i = 0; i < 30; i++) send($urandom);
      rnd_bp = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();
    end

    // Config guard: write while busy, illegal dims, write alongside in_valid
    out_ready = 1'b0;
    send(32'h1234_5678);
    @(posedge clk); #1;
    cfg_write(4'd0, 16'hFFFF);
    check("guard_busy_err", cfg_err, 1);
    @(posedge clk); #1;
    check("guard_busy_pulse", cfg_err, 0);
    out_ready = 1'b1;
    drain();
    cfg_dims(3'd0, 3'd1);
    check("guard_k0_err", cfg_err, 1);
    in_valid = 1'b1; in_data = 32'h9ABC_DEF0;
    cfg_wr = 1'b1; cfg_row = 4'd1; cfg_data = 16'hFFFF;
    #1 check("cfg_blocks_in", in_ready, 0);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    check("guard_inv_err", cfg_err, 1);
    send(32'h9ABC_DEF0);
    send(32'h1234_5678);
    drain();

    // Backpressure: two beats held, then three more stream through
    pulse_reset();
    out_ready = 1'b0;
    send(32'h1111_1111);
    send(32'h2222_2222);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    held = out_data;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 check("bp_hold_data", out_data, held);
        repeat (2) @(posedge clk);
        #2 out_ready = 1'b1;
      end
      begin
        send(32'h3333_3333);
        send(32'h4444_4444);
        send(32'h5555_5555);
      end
    join
    drain();
    check("bp_beat_cnt", beat_cnt, 5);

    // Asynchronous reset with a full pipeline
    out_ready = 1'b0;
    send(32'hAAAA_AAAA);
    send(32'h5555_AAAA);
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_beat_cnt", beat_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_out_data", out_data, 0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("arst_bm_zero", out_data, 0);
    check("arst_mask_all", out_mask, 4'hF);
    drain();

    // beat_cnt wrap after 65537 beats
    pulse_reset();
    for (int r = 0; r < 16; r++) cfg_write(4'(r), 16'($urandom));
    n_acc = 0;
    in_valid = 1'b1;
    for (int t = 0; t < 70000 && n_acc < 65537; t++) begin
      in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("wrap_accepted", n_acc, 65537);
    drain();
    check("wrap_beat_cnt", beat_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
